// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, even parity, stop bit.
// Each frame bit is held for CLKS_PER_BIT clocks; all outputs are registered.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     baud_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic              parity;
    logic              bit_done;

    assign bit_done = (baud_cnt == CNT_MAX);
    // Shift via a full-width vector so DATA_W=1 never indexes past bit 0.
    assign sh_next  = shreg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            tx_o     <= 1'b1;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        shreg    <= data_i;
                        parity   <= ^data_i;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                        tx_o     <= 1'b0;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx_o     <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_MAX) begin
                            state <= PARITY;
                            tx_o  <= parity;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= sh_next;
                            tx_o    <= sh_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx_o     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                        tx_o     <= 1'b1;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_o     <= 1'b1;
                    ready_o  <= 1'b1;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4): frames, back-to-back, busy ignore, reset abort.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},    32'(tx_o),    32'd1);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o),  32'd0);
    endtask

    // Called at E0+1; d and par are the hand-computed word and parity bit.
    // mid_valid/mid_data are driven right after accept to prove the frame ignores them.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic par,
                               input logic mid_valid, input logic [7:0] mid_data);
        logic [10:0] frame;
        frame = {1'b1, par, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("%s_tx_b%0d_c%0d", tag, k, c), 32'(tx_o), 32'(frame[k]));
                chk($sformatf("%s_busy_b%0d_c%0d", tag, k, c), 32'(busy_o), 32'd1);
                chk($sformatf("%s_ready_b%0d_c%0d", tag, k, c), 32'(ready_o), 32'd0);
                if (k == 0 && c == 0) begin
                    valid_i = mid_valid;
                    data_i  = mid_data;
                end
                step();
            end
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        // Reset held 2 cycles with a word offered: must not start a frame.
        reset = 1'b1; valid_i = 1'b1; data_i = 8'hFF;
        step();
        chk_idle("rst_e1");
        step();
        chk_idle("rst_e2");
        reset = 1'b0; valid_i = 1'b0;
        step();
        chk_idle("rst_post");

        // 0xA5: bits 1,0,1,0,0,1,0,1 parity 0
        valid_i = 1'b1; data_i = 8'hA5;
        step();
        valid_i = 1'b0;
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 8'hA5);
        step();
        chk_idle("a5_gap");

        // 0x07 parity 1, data_i cleared after accept
        valid_i = 1'b1; data_i = 8'h07;
        step();
        valid_i = 1'b0;
        check_frame("x07", 8'h07, 1'b1, 1'b0, 8'h00);
        step();

        // Back-to-back 0x3C then 0xC3 with valid held; one idle cycle between frames
        valid_i = 1'b1; data_i = 8'h3C;
        step();
        check_frame("x3c", 8'h3C, 1'b0, 1'b1, 8'hC3);
        step();
        valid_i = 1'b0;
        check_frame("xc3", 8'hC3, 1'b0, 1'b0, 8'hC3);
        step();

        // 0x13 (parity 1) with 0x55 offered throughout the frame
        valid_i = 1'b1; data_i = 8'h13;
        step();
        check_frame("busy", 8'h13, 1'b1, 1'b1, 8'h55);
        valid_i = 1'b0;
        step();
        chk_idle("busy_after");

        // Reset during data bit 3 of 0x0F (bit 3 spans E16..E20)
        valid_i = 1'b1; data_i = 8'h0F;
        step();
        valid_i = 1'b0; data_i = 8'h00;
        repeat (17) step();
        chk("abort_tx_bit3", 32'(tx_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd1);
        chk("abort_ready", 32'(ready_o), 32'd0);
        reset = 1'b1;
        step();
        chk_idle("abort_rst");
        reset = 1'b0;
        repeat (8) step();
        chk_idle("abort_no_resume");

        // 0x81 after abort: bits 1,0,0,0,0,0,0,1 parity 0
        valid_i = 1'b1; data_i = 8'h81;
        step();
        valid_i = 1'b0;
        check_frame("x81", 8'h81, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
